// File: rtl/arb_rsp_demux.sv
// arb_rsp_demux
// Keeps the arbitrated input index of each granted request in an in-order
// FIFO. Each returning response goes to the master at the FIFO head, so
// responses come back in the order their requests were granted.
module arb_rsp_demux #(
   parameter int unsigned NumOut    = 4,
   parameter int unsigned DataWidth = 32,
   parameter type         DataType  = logic [DataWidth-1:0],
   parameter int unsigned MaxTrans  = 4,
   parameter int unsigned IdxWidth  = $clog2(NumOut),
   parameter int unsigned CntWidth  = $clog2(MaxTrans + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                req_push_i,
   input  logic [IdxWidth-1:0] req_idx_i,
   output logic                req_ready_o,
   input  logic                rsp_valid_i,
   output logic                rsp_ready_o,
   input  DataType             rsp_data_i,
   output logic [NumOut-1:0]   rsp_valid_o,
   input  logic [NumOut-1:0]   rsp_ready_i,
   output DataType             rsp_data_o,
   output logic [IdxWidth-1:0] rsp_idx_o,
   output logic [CntWidth-1:0] cnt_o,
   output logic                err_o
);

   localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

   logic [IdxWidth-1:0] idx_q [MaxTrans];
   logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntWidth-1:0] cnt_q;
   logic                err_q;
   logic                full, empty, push, pop;
   logic [IdxWidth-1:0] head;

   // Wrap explicitly so depths that are not a power of two work too.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(MaxTrans - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign full  = (cnt_q == CntWidth'(MaxTrans));
   assign empty = (cnt_q == '0);
   assign head  = idx_q[rd_ptr_q];

   // A pop does not make room for a push in the same cycle, so
   // req_ready_o depends only on registered state.
   assign push        = req_push_i & ~full;
   assign pop         = rsp_valid_i & rsp_ready_o;
   assign req_ready_o = ~full;
   assign rsp_ready_o = ~empty & rsp_ready_i[head];
   assign rsp_data_o  = rsp_data_i;
   assign rsp_idx_o   = empty ? '0 : head;
   assign cnt_o       = cnt_q;
   assign err_o       = err_q;

   // Decode the head index into a one-hot valid. This is gated by empty,
   // so a push in the same cycle is never routed (no fall-through).
   always_comb begin
      rsp_valid_o = '0;
      for (int i = 0; i < NumOut; i++) begin
         if (rsp_valid_i && !empty && (head == IdxWidth'(i))) rsp_valid_o[i] = 1'b1;
      end
   end

   // Index storage. The entries are data, so they have no reset.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) idx_q[wr_ptr_q] <= req_idx_i;
   end

   // Pointers, occupancy and the sticky error flag. Flush overrides push and pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntWidth'(1);
            2'b01:   cnt_q <= cnt_q - CntWidth'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (rsp_valid_i && empty) err_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // A push while full is a protocol violation. The entry is dropped.
   push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(req_push_i && full))
      else $warning("arb_rsp_demux: push while full, entry dropped");
`endif

endmodule
